// File: rtl/pet_level_fsm.sv
// Need-level evaluator: derives a gated target stage from packed need levels and
// commits it through a hold/qualify counter. Optional macro LEVEL_JUMP_EN: commit jumps straight to cand.
module pet_level_fsm #(
    parameter int NUM_NEEDS   = 4,
    parameter int LVL_W       = 3,
    parameter int LOW_MAX     = 2,
    parameter int LVL_MAX     = 5,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_W     = $clog2(2*NUM_NEEDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_NEEDS*LVL_W-1:0] levels,
    input  logic                       level_valid,
    input  logic                       clr_err,
    output logic [STAGE_W-1:0]         stage,
    output logic                       stage_chg,
    output logic                       stage_up,
    output logic [STAGE_W-1:0]         cand,
    output logic                       err_range
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    logic [HC_W-1:0]    hold_cnt;
    logic [HC_W-1:0]    hold_nxt;
    logic [STAGE_W-1:0] tgt;
    logic               any_bad;
    logic               walking;
    logic [LVL_W-1:0]   lvl;
    logic               bad_k;
    logic               commit;

    function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] c);
        if (c >= HC_W'(HOLD_CYCLES))
            return HC_W'(HOLD_CYCLES);
        return c + 1'b1;
    endfunction

    function automatic logic [STAGE_W-1:0] step_toward(input logic [STAGE_W-1:0] cur,
                                                       input logic [STAGE_W-1:0] dst);
`ifdef LEVEL_JUMP_EN
        return dst;
`else
        return (dst > cur) ? cur + 1'b1 : cur - 1'b1;
`endif
    endfunction

    // Target walk: high needs advance the target, a low need pins it, a bad level stops the walk.
    always_comb begin
        tgt     = stage;
        walking = 1'b1;
        any_bad = 1'b0;
        lvl     = '0;
        bad_k   = 1'b0;
        for (int k = 0; k < NUM_NEEDS; k++) begin
            lvl   = levels[k*LVL_W +: LVL_W];
            bad_k = (lvl == '0) || (int'(lvl) > LVL_MAX);
            if (bad_k)
                any_bad = 1'b1;
            if (walking) begin
                if (bad_k) begin
                    walking = 1'b0;
                end else if (int'(lvl) <= LOW_MAX) begin
                    tgt     = STAGE_W'(2*k);
                    walking = 1'b0;
                end else begin
                    tgt = STAGE_W'(2*k + 1);
                end
            end
        end
    end

    // A new candidate counts as the first qualifying sample.
    always_comb begin
        hold_nxt = (tgt != cand) ? HC_W'(1) : sat_inc(hold_cnt);
        commit   = level_valid && (tgt != stage) && (hold_nxt == HC_W'(HOLD_CYCLES));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage     <= '0;
            cand      <= '0;
            hold_cnt  <= '0;
            stage_chg <= 1'b0;
            stage_up  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            stage_chg <= 1'b0;
            if (level_valid && any_bad)
                err_range <= 1'b1;
            else if (clr_err)
                err_range <= 1'b0;

            if (level_valid) begin
                cand <= tgt;
                if (tgt == stage) begin
                    hold_cnt <= '0;
                end else if (commit) begin
                    stage     <= step_toward(stage, tgt);
                    stage_chg <= 1'b1;
                    stage_up  <= (tgt > stage);
                    hold_cnt  <= '0;
                end else begin
                    hold_cnt <= hold_nxt;
                end
            end
        end
    end

endmodule
